ddr2_host_arbiter: RTL and testbench

DDR2_HOST_ARBITER -- requirements
Module: ddr2_host_arbiter

---
 rtl/ddr2_host_arbiter.sv | 142 ++++++++++++++
 tb/tb_ddr2_host_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_host_arbiter.sv
// Two-requester front-end arbiter for a DDR2 controller command/data FIFO pair.
// Define DDR2_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 first).
module ddr2_host_arbiter #(
  parameter int FILL_MAX = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        notfull,
  input  logic [6:0]  fillcount,
  input  logic        r0_req,
  input  logic [2:0]  r0_cmd,
  input  logic [1:0]  r0_sz,
  input  logic [2:0]  r0_op,
  input  logic [24:0] r0_addr,
  input  logic [15:0] r0_din,
  input  logic        r1_req,
  input  logic [2:0]  r1_cmd,
  input  logic [1:0]  r1_sz,
  input  logic [2:0]  r1_op,
  input  logic [24:0] r1_addr,
  input  logic [15:0] r1_din,
  output logic        r0_gnt,
  output logic        r0_dack,
  output logic        r1_gnt,
  output logic        r1_dack,
  output logic [2:0]  cmd,
  output logic [1:0]  sz,
  output logic [2:0]  op,
  output logic [24:0] addr,
  output logic [15:0] din,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, BLKW} state_t;

  localparam logic [2:0] CMD_SCR = 3'd1;
  localparam logic [2:0] CMD_SCW = 3'd2;
  localparam logic [2:0] CMD_BLR = 3'd3;
  localparam logic [2:0] CMD_BLW = 3'd4;
  localparam logic [2:0] CMD_ATR = 3'd5;
  localparam logic [2:0] CMD_ATW = 3'd6;

  function automatic logic is_read(input logic [2:0] c);
    return (c == CMD_SCR) || (c == CMD_BLR);
  endfunction

  function automatic logic is_write(input logic [2:0] c);
    return (c == CMD_SCW) || (c == CMD_BLW) || (c == CMD_ATR) || (c == CMD_ATW);
  endfunction

  state_t      state;
  logic [5:0]  count;
  logic        fill_ok;
  logic        elig0;
  logic        elig1;
  logic        pick;
  logic        word;

  assign fill_ok = int'(fillcount) <= FILL_MAX;
  assign elig0   = r0_req && ready && notfull &&
                   (is_read(r0_cmd) || (is_write(r0_cmd) && fill_ok));
  assign elig1   = r1_req && ready && notfull &&
                   (is_read(r1_cmd) || (is_write(r1_cmd) && fill_ok));

`ifdef DDR2_ARB_RR_EN
  logic rr_pri;

  assign pick = (elig0 && elig1) ? rr_pri : elig1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_pri <= 1'b0;
    end else if (state == IDLE && (elig0 || elig1)) begin
      rr_pri <= !pick;
    end
  end
`else
  assign pick = !elig0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      cmd    <= '0;
      sz     <= '0;
      op     <= '0;
      addr   <= '0;
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      owner  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            state  <= ISSUE;
            owner  <= pick;
            cmd    <= pick ? r1_cmd  : r0_cmd;
            sz     <= pick ? r1_sz   : r0_sz;
            op     <= pick ? r1_op   : r0_op;
            addr   <= pick ? r1_addr : r0_addr;
            r0_gnt <= !pick;
            r1_gnt <= pick;
          end
        end
        ISSUE: begin
          cmd    <= '0;
          sz     <= '0;
          op     <= '0;
          addr   <= '0;
          r0_gnt <= 1'b0;
          r1_gnt <= 1'b0;
          if (cmd == CMD_BLW) begin
            state <= BLKW;
            // Words still owed after the ISSUE word: 8*(SZ+1)-1.
            count <= {1'b0, sz, 3'b111};
          end else begin
            state <= IDLE;
          end
        end
        BLKW: begin
          if (fill_ok) begin
            count <= count - 6'd1;
            if (count == 6'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: DACK/DIN are decoded from registered state plus live inputs, so the word
  // passed through is the one the requester is holding in the consuming cycle.
  assign word    = (state == ISSUE && is_write(cmd)) || (state == BLKW && fill_ok);
  assign din     = word ? (owner ? r1_din : r0_din) : '0;
  assign r0_dack = word && !owner;
  assign r1_dack = word && owner;
  assign busy    = state != IDLE;

endmodule

// File: tb/tb_ddr2_host_arbiter.sv
// Directed bench for ddr2_host_arbiter: reset, grants, bursts, stalls, priority, reset mid-burst.
module tb_ddr2_host_arbiter;

`ifdef DDR2_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, ready, notfull;
  logic [6:0]  fillcount;
  logic        r0_req, r1_req;
  logic [2:0]  r0_cmd, r1_cmd, r0_op, r1_op;
  logic [1:0]  r0_sz, r1_sz;
  logic [24:0] r0_addr, r1_addr;
  logic [15:0] r0_din, r1_din;
  logic        r0_gnt, r0_dack, r1_gnt, r1_dack;
  logic [2:0]  cmd, op;
  logic [1:0]  sz;
  logic [24:0] addr;
  logic [15:0] din;
  logic        busy, owner;

  int errors = 0;
  int checks = 0;
  bit hold   = 1'b0;
  int dacks, blk;

  always #5 clk = ~clk;

  ddr2_host_arbiter dut (
    .clk(clk), .reset(reset), .ready(ready), .notfull(notfull), .fillcount(fillcount),
    .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_sz(r0_sz), .r0_op(r0_op), .r0_addr(r0_addr),
    .r0_din(r0_din),
    .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_sz(r1_sz), .r1_op(r1_op), .r1_addr(r1_addr),
    .r1_din(r1_din),
    .r0_gnt(r0_gnt), .r0_dack(r0_dack), .r1_gnt(r1_gnt), .r1_dack(r1_dack),
    .cmd(cmd), .sz(sz), .op(op), .addr(addr), .din(din), .busy(busy), .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester behaviour: drop REQ after GNT, present the next word after DACK.
  task automatic nxt();
    logic d0, d1, a0, a1;
    d0 = r0_gnt && !hold;
    d1 = r1_gnt && !hold;
    a0 = r0_dack;
    a1 = r1_dack;
    @(posedge clk);
    #1;
    if (d0) r0_req = 1'b0;
    if (d1) r1_req = 1'b0;
    if (a0) r0_din = r0_din + 16'd1;
    if (a1) r1_din = r1_din + 16'd1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; notfull = 1'b0; fillcount = '0;
    r0_req = 0; r0_cmd = 0; r0_sz = 0; r0_op = 0; r0_addr = 0; r0_din = 0;
    r1_req = 0; r1_cmd = 0; r1_sz = 0; r1_op = 0; r1_addr = 0; r1_din = 0;
    repeat (5) nxt();
    mid();
    check("rst_busy", busy, 0);
    check("rst_cmd", cmd, 0);
    check("rst_owner", owner, 0);
    check("rst_gnt", {r0_gnt, r1_gnt}, 0);
    check("rst_dack", {r0_dack, r1_dack}, 0);
    check("rst_din", din, 0);

    // Single read, first held back by READY=0
    nxt();
    reset = 1'b0; notfull = 1'b1; ready = 1'b0;
    r0_req = 1'b1; r0_cmd = 3'd1; r0_addr = 25'h1BABAFE;
    mid();
    nxt(); mid();
    check("ready_gate", busy, 0);
    nxt(); ready = 1'b1; mid();
    check("pre_grant_idle", busy, 0);
    nxt(); mid();
    check("scr_cmd", cmd, 1);
    check("scr_addr", addr, 32'h1BABAFE);
    check("scr_gnt", {r0_gnt, r1_gnt}, 2'b10);
    check("scr_dack", r0_dack, 0);
    check("scr_din", din, 0);
    check("scr_busy", busy, 1);
    nxt(); mid();
    check("scr_after_cmd", cmd, 0);
    check("scr_after_gnt", r0_gnt, 0);
    check("scr_after_busy", busy, 0);

    // NOP codes are never granted
    nxt();
    r0_req = 1'b1; r0_cmd = 3'd7; r1_req = 1'b1; r1_cmd = 3'd0;
    repeat (3) begin
      nxt(); mid();
      check("nop_ignored", busy, 0);
    end

    // R0 block write, SZ=1: 16 words
    nxt();
    r1_req = 1'b0;
    r0_req = 1'b1; r0_cmd = 3'd4; r0_sz = 2'd1; r0_op = 3'd5; r0_addr = 25'h0000100;
    r0_din = 16'hA000; fillcount = 7'd10;
    mid();
    nxt(); mid();
    check("blw_cmd", cmd, 4);
    check("blw_sz", sz, 1);
    check("blw_op", op, 5);
    check("blw_addr", addr, 32'h100);
    check("blw_gnt", r0_gnt, 1);
    check("blw_first_dack", r0_dack, 1);
    check("blw_first_din", din, 32'hA000);
    dacks = int'(r0_dack);
    for (int k = 1; k <= 15; k++) begin
      nxt(); mid();
      check("blw_dack", r0_dack, 1);
      check("blw_din", din, 32'hA000 + k);
      check("blw_busy", busy, 1);
      check("blw_cmd_zero", cmd, 0);
      dacks += int'(r0_dack);
    end
    nxt(); mid();
    check("blw_end_busy", busy, 0);
    check("blw_end_dack", r0_dack, 0);
    check("blw_total", dacks, 16);

    // R1 block write, SZ=0, FILLCOUNT over the limit for 3 BLKW cycles
    nxt();
    r1_req = 1'b1; r1_cmd = 3'd4; r1_sz = 2'd0; r1_addr = 25'h1FFFFFF;
    r1_din = 16'h5000; fillcount = 7'd0;
    mid();
    nxt(); mid();
    check("stall_gnt", r1_gnt, 1);
    check("stall_owner", owner, 1);
    check("stall_addr", addr, 32'h1FFFFFF);
    check("stall_first_din", din, 32'h5000);
    dacks = int'(r1_dack);
    blk = 0;
    for (int i = 1; i <= 20; i++) begin
      nxt();
      fillcount = (i >= 3 && i <= 5) ? 7'd64 : 7'd0;
      mid();
      if (!busy) break;
      blk++;
      if (i >= 3 && i <= 5) begin
        check("stall_dack", r1_dack, 0);
        check("stall_din", din, 0);
      end else begin
        check("stall_burst_din", din, 32'h5000 + dacks);
      end
      dacks += int'(r1_dack);
    end
    check("stall_blkw_cycles", blk, 10);
    check("stall_total", dacks, 8);
    check("stall_end_dack", r1_dack, 0);

    // Read passes a write stalled on FILLCOUNT; write goes at FILLCOUNT=63
    nxt();
    r0_req = 1'b1; r0_cmd = 3'd2; r0_addr = 25'h0ABCDEF; r0_din = 16'h1234;
    r1_req = 1'b1; r1_cmd = 3'd1; r1_addr = 25'h0000042; fillcount = 7'd64;
    mid();
    check("pass_idle", busy, 0);
    nxt(); mid();
    check("pass_gnt", {r0_gnt, r1_gnt}, 2'b01);
    check("pass_cmd", cmd, 1);
    check("pass_addr", addr, 32'h42);
    check("pass_read_din", din, 0);
    check("pass_read_dack", r1_dack, 0);
    nxt(); mid();
    check("pass_gap", busy, 0);
    nxt(); mid();
    check("write_blocked", busy, 0);
    nxt(); fillcount = 7'd63; mid();
    check("write_still_idle", busy, 0);
    nxt(); mid();
    check("write_gnt", {r0_gnt, r1_gnt}, 2'b10);
    check("write_cmd", cmd, 2);
    check("write_dack", r0_dack, 1);
    check("write_din", din, 32'h1234);
    check("write_owner", owner, 0);
    nxt(); mid();
    check("write_end", busy, 0);

    // Both requesters continuously asking: fixed priority or alternation
    nxt();
    reset = 1'b1;
    mid();
    nxt();
    reset = 1'b0; hold = 1'b1; fillcount = 7'd0;
    r0_req = 1'b1; r0_cmd = 3'd1; r1_req = 1'b1; r1_cmd = 3'd1;
    mid();
    check("arb_idle", busy, 0);
    for (int g = 0; g < 4; g++) begin
      nxt(); mid();
      check("arb_cmd", cmd, 1);
      check("arb_owner", owner, RR ? (g % 2) : 0);
      check("arb_gnt", {r0_gnt, r1_gnt}, (RR && (g % 2 == 1)) ? 2'b01 : 2'b10);
      nxt(); mid();
      check("arb_gap", busy, 0);
    end
    r0_req = 1'b0; r1_req = 1'b0; hold = 1'b0;

    // R1 burst ignores READY/NOTFULL drop, then reset on the 5th BLKW cycle
    nxt();
    r1_req = 1'b1; r1_cmd = 3'd4; r1_sz = 2'd3; r1_addr = 25'h0000200; r1_din = 16'h7700;
    mid();
    nxt(); mid();
    check("rstb_gnt", r1_gnt, 1);
    check("rstb_sz", sz, 3);
    check("rstb_dack", r1_dack, 1);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      if (i == 2) begin
        ready = 1'b0; notfull = 1'b0;
      end
      mid();
      check("rstb_blkw_dack", r1_dack, 1);
      check("rstb_blkw_din", din, 32'h7700 + i);
    end
    nxt(); reset = 1'b1; mid();
    check("rstb_5th_busy", busy, 1);
    nxt(); mid();
    check("rstb_busy", busy, 0);
    check("rstb_cmd", cmd, 0);
    check("rstb_dack", r1_dack, 0);
    check("rstb_owner", owner, 0);
    check("rstb_din", din, 0);
    nxt();
    reset = 1'b0; ready = 1'b1; notfull = 1'b1;
    mid();
    nxt(); mid();
    check("rstb_abandoned_dack", r1_dack, 0);
    check("rstb_abandoned_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
